// File: rtl/lighthouse_emulator_pkg.sv
// Shared definitions for the lighthouse pulse-train emulator: register map,
// control bit positions and the frame state encoding.
package lighthouse_emu_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_SYNC   = 3'd1;
  localparam logic [2:0] ADDR_DELAY  = 3'd2;
  localparam logic [2:0] ADDR_SWEEP  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_MASK   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_FRAMES = 3'd7;

  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_SINGLE_SHOT_BIT = 1;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  // Phases are numbered so that a phase's encoding equals the index of the
  // phase that follows it (SYNC=1 -> GAP is phase index 1, ...).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_GAP   = 3'd2,
    ST_SWEEP = 3'd3,
    ST_TAIL  = 3'd4
  } state_t;

  function automatic logic is_pulse_state(input state_t s);
    return (s == ST_SYNC) || (s == ST_SWEEP);
  endfunction

endpackage

// File: rtl/lighthouse_emulator_if.sv
// Avalon-MM slave bus used to configure the lighthouse emulator.
interface lighthouse_emulator_if;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (output address, write, writedata, read, input readdata, waitrequest);
  modport slave  (input address, write, writedata, read, output readdata, waitrequest);
endinterface

// File: rtl/lighthouse_frame_fsm.sv
// Frame sequencer: latches timing shadows at frame start and walks
// SYNC/GAP/SWEEP/TAIL with a single down-counter, skipping zero-length phases.
module lighthouse_frame_fsm
  import lighthouse_emu_pkg::*;
#(
  parameter int NUM_SENSORS = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   single_shot,
  input  logic [CNT_W-1:0]       sync_width,
  input  logic [CNT_W-1:0]       sweep_delay,
  input  logic [CNT_W-1:0]       sweep_width,
  input  logic [CNT_W-1:0]       period,
  input  logic [NUM_SENSORS-1:0] lane_mask,
  output state_t                 state,
  output logic                   pulse,
  output logic                   frame_start,
  output logic [NUM_SENSORS-1:0] lane_mask_shadow
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef struct packed {
    state_t           st;
    logic [CNT_W-1:0] dur;
  } phase_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   pulse_reg;
  logic                   frame_start_reg;
  logic [CNT_W-1:0]       sync_sh_reg;
  logic [CNT_W-1:0]       delay_sh_reg;
  logic [CNT_W-1:0]       sweep_sh_reg;
  logic [CNT_W-1:0]       tail_sh_reg;
  logic [NUM_SENSORS-1:0] mask_sh_reg;

  logic [SUM_W-1:0] live_sum;
  logic [SUM_W-1:0] live_period;
  logic [CNT_W-1:0] live_tail;
  phase_t           in_frame_next;
  phase_t           fresh_next;
  logic             launch;

  // First phase at or after index 'first' with a non-zero duration; IDLE when none remain.
  function automatic phase_t seek(input logic [2:0] first,
                                  input logic [CNT_W-1:0] d0, d1, d2, d3);
    phase_t p;
    p.st  = ST_IDLE;
    p.dur = '0;
    if (first <= 3'd3 && d3 != '0) begin p.st = ST_TAIL;  p.dur = d3; end
    if (first <= 3'd2 && d2 != '0) begin p.st = ST_SWEEP; p.dur = d2; end
    if (first <= 3'd1 && d1 != '0) begin p.st = ST_GAP;   p.dur = d1; end
    if (first == 3'd0 && d0 != '0) begin p.st = ST_SYNC;  p.dur = d0; end
    return p;
  endfunction

  // Tail fills the frame out to 'period'; an all-zero config still yields one low cycle.
  always_comb begin
    live_sum    = SUM_W'(sync_width) + SUM_W'(sweep_delay) + SUM_W'(sweep_width);
    live_period = SUM_W'(period);
    if (live_period > live_sum)
      live_tail = CNT_W'(live_period - live_sum);
    else if (live_sum == '0)
      live_tail = ONE;
    else
      live_tail = '0;
  end

  always_comb begin
    in_frame_next = seek(state_reg, sync_sh_reg, delay_sh_reg, sweep_sh_reg, tail_sh_reg);
    fresh_next    = seek(3'd0, sync_width, sweep_delay, sweep_width, live_tail);
    launch = ((state_reg == ST_IDLE) && (enable || single_shot)) ||
             ((state_reg != ST_IDLE) && (cnt_reg == '0) &&
              (in_frame_next.st == ST_IDLE) && enable);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      pulse_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      sync_sh_reg     <= '0;
      delay_sh_reg    <= '0;
      sweep_sh_reg    <= '0;
      tail_sh_reg     <= '0;
      mask_sh_reg     <= '0;
    end else begin
      frame_start_reg <= 1'b0;
      if (launch) begin
        sync_sh_reg     <= sync_width;
        delay_sh_reg    <= sweep_delay;
        sweep_sh_reg    <= sweep_width;
        tail_sh_reg     <= live_tail;
        mask_sh_reg     <= lane_mask;
        state_reg       <= fresh_next.st;
        cnt_reg         <= fresh_next.dur - ONE;
        pulse_reg       <= is_pulse_state(fresh_next.st);
        frame_start_reg <= 1'b1;
      end else if (state_reg != ST_IDLE) begin
        if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - ONE;
        end else if (in_frame_next.st != ST_IDLE) begin
          state_reg <= in_frame_next.st;
          cnt_reg   <= in_frame_next.dur - ONE;
          pulse_reg <= is_pulse_state(in_frame_next.st);
        end else begin
          state_reg <= ST_IDLE;
          pulse_reg <= 1'b0;
        end
      end
    end
  end

  assign state            = state_reg;
  assign pulse            = pulse_reg;
  assign frame_start      = frame_start_reg;
  assign lane_mask_shadow = mask_sh_reg;

endmodule

// File: rtl/lighthouse_emulator.sv
// Lighthouse emulator top: Avalon register file, readback mux, frame counter
// and per-lane masking of the sequencer's pulse onto the sensor lines.
module lighthouse_emulator
  import lighthouse_emu_pkg::*;
#(
  parameter int NUM_SENSORS = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  lighthouse_emulator_if.slave   avs,
  output logic [NUM_SENSORS-1:0] sensor_signal_o,
  output logic                   frame_start_o
);

  logic                   enable_reg;
  logic                   single_shot_reg;
  logic [CNT_W-1:0]       sync_width_reg;
  logic [CNT_W-1:0]       sweep_delay_reg;
  logic [CNT_W-1:0]       sweep_width_reg;
  logic [CNT_W-1:0]       period_reg;
  logic [NUM_SENSORS-1:0] lane_mask_reg;
  logic [CNT_W-1:0]       frame_count_reg;
  logic [NUM_SENSORS-1:0] sensor_reg;
  logic [NUM_SENSORS-1:0] sensor_next;
  logic [31:0]            readdata_mux;

  state_t                 fsm_state;
  logic                   fsm_pulse;
  logic                   fsm_frame_start;
  logic [NUM_SENSORS-1:0] mask_shadow;
  logic                   busy;

  lighthouse_frame_fsm #(
    .NUM_SENSORS (NUM_SENSORS),
    .CNT_W       (CNT_W)
  ) u_frame_fsm (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable_reg),
    .single_shot      (single_shot_reg),
    .sync_width       (sync_width_reg),
    .sweep_delay      (sweep_delay_reg),
    .sweep_width      (sweep_width_reg),
    .period           (period_reg),
    .lane_mask        (lane_mask_reg),
    .state            (fsm_state),
    .pulse            (fsm_pulse),
    .frame_start      (fsm_frame_start),
    .lane_mask_shadow (mask_shadow)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_reg      <= 1'b0;
      single_shot_reg <= 1'b0;
      sync_width_reg  <= '0;
      sweep_delay_reg <= '0;
      sweep_width_reg <= '0;
      period_reg      <= '0;
      lane_mask_reg   <= '0;
      frame_count_reg <= '0;
    end else begin
      single_shot_reg <= 1'b0;
      if (avs.write) begin
        case (avs.address)
          ADDR_CTRL: begin
            enable_reg      <= avs.writedata[CTRL_ENABLE_BIT];
            single_shot_reg <= avs.writedata[CTRL_SINGLE_SHOT_BIT];
          end
          ADDR_SYNC:   sync_width_reg  <= avs.writedata[CNT_W-1:0];
          ADDR_DELAY:  sweep_delay_reg <= avs.writedata[CNT_W-1:0];
          ADDR_SWEEP:  sweep_width_reg <= avs.writedata[CNT_W-1:0];
          ADDR_PERIOD: period_reg      <= avs.writedata[CNT_W-1:0];
          ADDR_MASK:   lane_mask_reg   <= avs.writedata[NUM_SENSORS-1:0];
          default: ;
        endcase
      end
      if (fsm_frame_start)
        frame_count_reg <= frame_count_reg + CNT_W'(1);
    end
  end

  assign busy = (fsm_state != ST_IDLE);

  // Unused bits read back as the DEADBEEF filler so software can spot them.
  always_comb begin
    readdata_mux = DEADBEEF;
    case (avs.address)
      ADDR_CTRL: begin
        readdata_mux[CTRL_ENABLE_BIT]      = enable_reg;
        readdata_mux[CTRL_SINGLE_SHOT_BIT] = 1'b0;
      end
      ADDR_SYNC:   readdata_mux[CNT_W-1:0]       = sync_width_reg;
      ADDR_DELAY:  readdata_mux[CNT_W-1:0]       = sweep_delay_reg;
      ADDR_SWEEP:  readdata_mux[CNT_W-1:0]       = sweep_width_reg;
      ADDR_PERIOD: readdata_mux[CNT_W-1:0]       = period_reg;
      ADDR_MASK:   readdata_mux[NUM_SENSORS-1:0] = lane_mask_reg;
      ADDR_STATUS: readdata_mux                  = {28'b0, busy, fsm_state};
      ADDR_FRAMES: readdata_mux[CNT_W-1:0]       = frame_count_reg;
      default: ;
    endcase
  end

  assign avs.readdata    = readdata_mux;
  assign avs.waitrequest = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_lane
      assign sensor_next[gi] = fsm_pulse & mask_shadow[gi];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      sensor_reg <= '0;
    else
      sensor_reg <= sensor_next;
  end

  assign sensor_signal_o = sensor_reg;
  assign frame_start_o   = fsm_frame_start;

endmodule
